axi_master_engine: RTL and testbench
====================================

AXI_MASTER_ENGINE -- requirements
Module: axi_master_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data bus width in bits (32 or 64).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-003 SHALL have parameter ID_W, default 4, meaning AXI ID width.
REQ-004 SHALL have parameter TIMEOUT, default 1024, meaning watchdog limit in cycles per handshake wait.
REQ-005 aclk  in  1  single clock; all logic on rising edge.
REQ-006 areset  in  1  reset, synchronous, active-high.
REQ-007 cmd_valid, cmd_ready  in/out  1/1  command handshake.
REQ-008 cmd_write, cmd_addr, cmd_len, cmd_size, cmd_burst, cmd_id  in  1/ADDR_W/4/3/2/ID_W  command fields; cmd_len = beats-1.
REQ-009 wd_valid, wd_ready, wd_data, wd_strb  in/out/in/in  1/1/DATA_W/DATA_W/8  write-data stream.
REQ-010 rd_valid, rd_ready, rd_data, rd_last  out/in/out/out  1/1/DATA_W/1  read-data stream.
REQ-011 done_valid, done_resp, done_timeout  out  1/2/1  one-cycle completion pulse, response, watchdog flag.
REQ-012 awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid  out; awready  in  AXI3 write address channel.
REQ-013 wid, wdata, wstrb, wlast, wvalid  out; wready  in  AXI3 write data channel.
REQ-014 bid, bresp, bvalid  in; bready  out  write response channel (master receives B).
REQ-015 arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid  out; arready  in  read address channel.
REQ-016 rid, rdata, rresp, rlast, rvalid  in; rready  out  read data channel.

Function
REQ-017 FSM states SHALL be IDLE, AW, W, B, AR, R, DONE.
REQ-018 IDLE: cmd_ready=1; on cmd_valid&cmd_ready latch all fields, go AW if cmd_write else AR.
REQ-019 AW/AR: valid held high with stable fields until ready sampled high on a clock edge; then valid=0 and go W/R next cycle.
REQ-020 awlock/arlock=0, awcache/arcache=0, awprot/arprot=0 constant.
REQ-021 W: wvalid=wd_valid, wd_ready=wready; beat transfers when wvalid&wready; beat counter increments; wlast=1 exactly on beat cmd_len; after last beat go B.
REQ-022 wid and bid check: wid=latched id; B: bready=1; on bvalid capture bresp, go DONE; bid mismatch forces done_resp=2'b10.
REQ-023 R: rready=rd_ready; rd_valid=rvalid; rd_data/rd_last pass rdata/rlast; worst rresp over burst accumulated (max value); on rlast transfer go DONE.
REQ-024 rlast arriving before beat cmd_len, or absent at beat cmd_len, SHALL force done_resp=2'b10.
REQ-025 DONE: done_valid=1 for exactly one cycle, then IDLE; cmd_ready=0 in all non-IDLE states.
REQ-026 Watchdog: counter clears on every handshake, increments while waiting in AW/W/B/AR/R; at TIMEOUT deassert all valid/ready, done_timeout=1, done_resp=2'b10, go DONE.
REQ-027 Address outputs SHALL be held stable; wdata/wstrb driven 0 when wvalid=0.
REQ-028 Back-to-back commands: a new command SHALL be accepted the cycle after DONE (min 1 idle cycle).

Reset
REQ-029 areset SHALL return FSM to IDLE and drive every output to 0 (cmd_ready=1 only after reset deasserts), regardless of state.
REQ-030 Reset mid-burst SHALL abandon the transaction with no done_valid pulse.

Structure
REQ-031 State encoding, burst-type, lock, response codes (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3) SHALL live in shared package axi_pkg.
REQ-032 Watchdog SHALL be a sub-module axi_watchdog (clear, enable, expired).

Verification
REQ-033 Single write addr 0x100 data 0xDEADBEEF strb 0xF, slave awready after 2 cycles -> awlen=0, wlast=1 on beat 0, done_resp=0.
REQ-034 4-beat INCR read addr 0x200 (cmd_len=3), slave returns 0x1..0x4 with rd_ready toggling -> rd_data 0x1..0x4 in order, rd_last on 4th, done_resp=0.
REQ-035 Read with rresp=2 on beat 2 of 4 -> done_resp=2.
REQ-036 Slave never asserts awready, TIMEOUT=16 -> awvalid drops after 16 cycles, done_timeout=1, done_resp=2.
REQ-037 areset asserted during W beat 2 of 8 -> all outputs 0 next cycle, no done_valid, next command completes normally.
REQ-038 Write with bid=5 vs cmd_id=3 -> done_resp=2.

Source files
------------

// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI3 encodings and the engine state type.
package axi_pkg;
    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_e;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;
    localparam logic [1:0] LOCK_NORMAL = 2'b00;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/axi_watchdog.sv
// axi_watchdog: counts cycles spent waiting on a handshake and flags when the limit is reached.
module axi_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        expired = enable && (cnt_q >= CW'(TIMEOUT));
        cnt_d = (clear || !enable) ? '0 : (expired ? cnt_q : cnt_q + CW'(1));
    end
    always_ff @(posedge clk) begin
        cnt_q <= rst ? '0 : cnt_d;
    end
endmodule

// File: rtl/axi_master_engine.sv
// axi_master_engine: single-outstanding AXI3 master turning one command into an AW/W/B or AR/R
// transaction, with a per-handshake watchdog and a one-cycle completion pulse.
module axi_master_engine
    import axi_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [3:0]          cmd_len,
    input  logic [2:0]          cmd_size,
    input  logic [1:0]          cmd_burst,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_last,
    output logic                done_valid,
    output logic [1:0]          done_resp,
    output logic                done_timeout,
    output logic [ID_W-1:0]     awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [3:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic [1:0]          awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,
    output logic [ID_W-1:0]     wid,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [ID_W-1:0]     bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [ID_W-1:0]     arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic [3:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic [1:0]          arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,
    input  logic [ID_W-1:0]     rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready
);
    state_e            state_q, state_d, cur;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        len_q, len_d, beat_q, beat_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d, resp_q, resp_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              err_q, err_d, to_q, to_d;
    logic              wd_clr, wd_en, wd_exp;

    assign awlock = LOCK_NORMAL;
    assign arlock = LOCK_NORMAL;
    assign awcache = '0;
    assign arcache = '0;
    assign awprot = '0;
    assign arprot = '0;
    // Reset forces the output decode to IDLE so every output is low while areset is held.
    assign cur = areset ? S_IDLE : state_q;
    assign wd_en = !(cur inside {S_IDLE, S_DONE});

    axi_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk(aclk),
        .rst(areset),
        .clear(wd_clr),
        .enable(wd_en),
        .expired(wd_exp)
    );

    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        len_d = len_q;
        size_d = size_q;
        burst_d = burst_q;
        id_d = id_q;
        beat_d = beat_q;
        resp_d = resp_q;
        err_d = err_q;
        to_d = to_q;
        wd_clr = 1'b0;
        cmd_ready = 1'b0;
        wd_ready = 1'b0;
        rd_valid = 1'b0;
        rd_data = '0;
        rd_last = 1'b0;
        done_valid = 1'b0;
        done_resp = RESP_OKAY;
        done_timeout = 1'b0;
        awid = '0;
        awaddr = '0;
        awlen = '0;
        awsize = '0;
        awburst = '0;
        awvalid = 1'b0;
        wid = '0;
        wdata = '0;
        wstrb = '0;
        wlast = 1'b0;
        wvalid = 1'b0;
        bready = 1'b0;
        arid = '0;
        araddr = '0;
        arlen = '0;
        arsize = '0;
        arburst = '0;
        arvalid = 1'b0;
        rready = 1'b0;
        unique case (cur)
            S_IDLE: begin
                cmd_ready = !areset;
                if (cmd_valid && !areset) begin
                    state_d = cmd_write ? S_AW : S_AR;
                    addr_d = cmd_addr;
                    len_d = cmd_len;
                    size_d = cmd_size;
                    burst_d = cmd_burst;
                    id_d = cmd_id;
                    beat_d = '0;
                    resp_d = RESP_OKAY;
                    err_d = 1'b0;
                    to_d = 1'b0;
                end
            end
            S_AW: begin
                awvalid = !wd_exp;
                awid = id_q;
                awaddr = addr_q;
                awlen = len_q;
                awsize = size_q;
                awburst = burst_q;
                wd_clr = awvalid && awready;
                state_d = wd_clr ? S_W : state_q;
            end
            S_W: begin
                wvalid = wd_valid && !wd_exp;
                wd_ready = wready && !wd_exp;
                wid = id_q;
                wdata = wvalid ? wd_data : '0;
                wstrb = wvalid ? wd_strb : '0;
                wlast = wvalid && (beat_q == len_q);
                wd_clr = wvalid && wready;
                beat_d = wd_clr ? beat_q + 4'd1 : beat_q;
                state_d = (wd_clr && wlast) ? S_B : state_q;
            end
            S_B: begin
                bready = !wd_exp;
                wd_clr = bvalid && bready;
                if (wd_clr) begin
                    resp_d = bresp;
                    err_d = err_q || (bid != id_q);
                    state_d = S_DONE;
                end
            end
            S_AR: begin
                arvalid = !wd_exp;
                arid = id_q;
                araddr = addr_q;
                arlen = len_q;
                arsize = size_q;
                arburst = burst_q;
                wd_clr = arvalid && arready;
                state_d = wd_clr ? S_R : state_q;
            end
            S_R: begin
                rready = rd_ready && !wd_exp;
                rd_valid = rvalid && !wd_exp;
                rd_data = rd_valid ? rdata : '0;
                rd_last = rd_valid && rlast;
                wd_clr = rvalid && rready;
                // Any beat whose rlast disagrees with the expected final beat marks a protocol error.
                if (wd_clr) begin
                    beat_d = beat_q + 4'd1;
                    resp_d = resp_max(resp_q, rresp);
                    err_d = err_q || (rid != id_q) || (rlast != (beat_q == len_q));
                    state_d = rlast ? S_DONE : state_q;
                end
            end
            S_DONE: begin
                done_valid = 1'b1;
                done_resp = err_q ? RESP_SLVERR : resp_q;
                done_timeout = to_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (wd_exp) begin
            state_d = S_DONE;
            err_d = 1'b1;
            to_d = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= S_IDLE;
            addr_q <= '0;
            len_q <= '0;
            size_q <= '0;
            burst_q <= '0;
            id_q <= '0;
            beat_q <= '0;
            resp_q <= RESP_OKAY;
            err_q <= 1'b0;
            to_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            len_q <= len_d;
            size_q <= size_d;
            burst_q <= burst_d;
            id_q <= id_d;
            beat_q <= beat_d;
            resp_q <= resp_d;
            err_q <= err_d;
            to_q <= to_d;
        end
    end
endmodule

// File: tb/tb_axi_master_engine.sv
// tb_axi_master_engine: command table run against a behavioural AXI3 slave, with reset checks.
`timescale 1ns/1ps
module tb_axi_master_engine;
    localparam int TO = 16;
    logic        aclk = 1'b0, areset = 1'b1;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic [3:0]  cmd_id;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic [3:0]  wd_strb;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done_valid, done_timeout;
    logic [1:0]  done_resp;
    logic [3:0]  awid, awlen, awcache, wid, bid, arid, arlen, arcache, rid, wstrb;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [2:0]  awsize, awprot, arsize, arprot;
    logic [1:0]  awburst, awlock, arburst, arlock, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        any_out;

    always #5 aclk = ~aclk;

    axi_master_engine #(.DATA_W(32), .ADDR_W(32), .ID_W(4), .TIMEOUT(TO)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_id(cmd_id),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done_valid(done_valid), .done_resp(done_resp), .done_timeout(done_timeout),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    assign any_out = |{cmd_ready, wd_ready, rd_valid, rd_data, rd_last, done_valid, done_resp,
                       done_timeout, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
                       awvalid, wid, wdata, wstrb, wlast, wvalid, bready, arid, araddr, arlen,
                       arsize, arburst, arlock, arcache, arprot, arvalid, rready};

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [3:0]  id;
        int          dly;
        logic [3:0]  sid;
        int          err_beat;
        logic [1:0]  err_resp;
        int          last_at;
        logic        tog;
        int          rst_beat;
        logic [1:0]  exp_resp;
        logic        exp_to;
    } vec_t;

    vec_t        tbl[11];
    int          n_chk = 0, n_fail = 0;
    logic [1:0]  r;
    logic        t, ab, seen;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle_bus();
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0; cmd_burst = 0; cmd_id = 0;
        wd_valid = 0; wd_data = 0; wd_strb = 0; rd_ready = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0; arready = 0;
        rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    endtask

    // Issues one command, then plays the slave cycle by cycle until done_valid or a reset abort.
    task automatic run(input vec_t v, output logic [1:0] resp, output logic tmo, output logic aborted);
        int   aw_seen = 0, ar_seen = 0, wb = 0, rb = 0;
        logic w_ph = 0, b_ph = 0, r_ph = 0, got = 0;
        resp = 2'b00; tmo = 1'b0; aborted = 1'b0;
        cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
        cmd_size = 3'd2; cmd_burst = 2'b01; cmd_id = v.id;
        @(posedge aclk); #1;
        cmd_valid = 0;
        for (int c = 0; c < 200 && !got && !aborted; c++) begin
            awready = aw_seen >= v.dly;
            arready = ar_seen >= v.dly;
            wready = 1; wd_valid = w_ph; wd_data = 32'hDEADBEEF + 32'(wb); wd_strb = 4'hF;
            bvalid = b_ph; bid = v.sid; bresp = 2'b00;
            rvalid = r_ph; rid = v.sid; rdata = 32'(rb + 1);
            rresp = (rb == v.err_beat) ? v.err_resp : 2'b00;
            rlast = (rb == v.last_at);
            rd_ready = !v.tog || c[0];
            areset = w_ph && (wb == v.rst_beat);
            #1;
            if (areset) aborted = 1'b1;
            else begin
                if (awvalid) begin
                    aw_seen++;
                    if (awready) begin
                        check("awaddr", awaddr, v.addr);
                        check("awlen", awlen, v.len);
                        check("awid", awid, v.id);
                        w_ph = 1;
                    end
                end
                if (wvalid && wready) begin
                    check("wdata", wdata, 32'hDEADBEEF + 32'(wb));
                    check("wstrb", wstrb, 4'hF);
                    check("wlast", wlast, wb == int'(v.len));
                    check("wid", wid, v.id);
                    wb++;
                    if (wb > int'(v.len)) begin w_ph = 0; b_ph = 1; end
                end
                if (bvalid && bready) b_ph = 0;
                if (arvalid) begin
                    ar_seen++;
                    if (arready) begin
                        check("araddr", araddr, v.addr);
                        check("arlen", arlen, v.len);
                        r_ph = 1;
                    end
                end
                if (rvalid && rready) begin
                    check("rd_valid", rd_valid, 1);
                    check("rd_data", rd_data, 32'(rb + 1));
                    check("rd_last", rd_last, rb == v.last_at);
                    rb++;
                    if (rlast) r_ph = 0;
                end
                if (done_valid) begin
                    got = 1;
                    resp = done_resp;
                    tmo = done_timeout;
                    check("cmd_ready_in_done", cmd_ready, 0);
                end else begin
                    @(posedge aclk); #1;
                end
            end
        end
        if (!aborted) check("done_seen", got, 1);
        if (v.dly >= 99) check("awvalid_cycles", aw_seen, TO);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'h100, 4'd0, 4'd3, 2,  4'd3, -1, 2'd0, 0, 1'b0, -1, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 32'h200, 4'd3, 4'd1, 0,  4'd1, -1, 2'd0, 3, 1'b1, -1, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 32'h200, 4'd3, 4'd1, 0,  4'd1,  2, 2'd2, 3, 1'b0, -1, 2'd2, 1'b0};
        tbl[3]  = '{1'b1, 32'h300, 4'd0, 4'd3, 0,  4'd5, -1, 2'd0, 0, 1'b0, -1, 2'd2, 1'b0};
        tbl[4]  = '{1'b0, 32'h400, 4'd3, 4'd2, 1,  4'd2, -1, 2'd0, 1, 1'b0, -1, 2'd2, 1'b0};
        tbl[5]  = '{1'b0, 32'h500, 4'd1, 4'd2, 0,  4'd2, -1, 2'd0, 5, 1'b0, -1, 2'd2, 1'b0};
        tbl[6]  = '{1'b1, 32'h600, 4'd0, 4'd4, 99, 4'd4, -1, 2'd0, 0, 1'b0, -1, 2'd2, 1'b1};
        tbl[7]  = '{1'b1, 32'h700, 4'd7, 4'd6, 0,  4'd6, -1, 2'd0, 0, 1'b0,  2, 2'd0, 1'b0};
        tbl[8]  = '{1'b1, 32'h800, 4'd3, 4'd6, 1,  4'd6, -1, 2'd0, 0, 1'b0, -1, 2'd0, 1'b0};
        tbl[9]  = '{1'b0, 32'h900, 4'd1, 4'd7, 0,  4'd7,  0, 2'd1, 1, 1'b0, -1, 2'd1, 1'b0};
        tbl[10] = '{1'b0, 32'hA00, 4'd2, 4'd7, 0,  4'd7,  1, 2'd3, 2, 1'b1, -1, 2'd3, 1'b0};
        idle_bus();
        areset = 1;
        repeat (3) @(posedge aclk);
        #2;
        check("outputs_in_reset", any_out, 0);
        areset = 0;
        #1;
        check("cmd_ready_after_reset", cmd_ready, 1);
        foreach (tbl[i]) begin
            run(tbl[i], r, t, ab);
            if (tbl[i].rst_beat >= 0) begin
                check("reset_abort", ab, 1);
                @(posedge aclk); #1;
                check("outputs_after_mid_reset", any_out, 0);
                areset = 0;
                idle_bus();
                seen = 0;
                for (int k = 0; k < 4; k++) begin
                    @(posedge aclk); #2;
                    seen |= done_valid;
                end
                check("no_done_after_reset", seen, 0);
                check("cmd_ready_post_reset", cmd_ready, 1);
            end else begin
                check($sformatf("done_resp_%0d", i), r, tbl[i].exp_resp);
                check($sformatf("done_timeout_%0d", i), t, tbl[i].exp_to);
                idle_bus();
                @(posedge aclk); #2;
                check("cmd_ready_back_to_back", cmd_ready, 1);
                check("done_single_pulse", done_valid, 0);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end
endmodule
